// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO round-robin scheduler.
// Holds the scheduler state encoding and the quantum normalisation rule.
package fifo_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_e;

    // Widest quantum field the normalisation helper handles.
    localparam int unsigned MAX_QUANTUM_WIDTH = 16;

    // A zero quantum would stall a grant forever, so it is served as one word.
    function automatic logic [MAX_QUANTUM_WIDTH-1:0] quantum_norm(
        input logic [MAX_QUANTUM_WIDTH-1:0] q
    );
        return (q == '0) ? MAX_QUANTUM_WIDTH'(1) : q;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first set request at or after base,
// wrapping modulo NUM_PORTS.
module rr_pick #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned PORT_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [PORT_WIDTH-1:0] base,
    output logic                  hit,
    output logic [PORT_WIDTH-1:0] grant
);

    always_comb begin
        int unsigned idx;
        hit   = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(base) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!hit && req[idx]) begin
                hit   = 1'b1;
                grant = PORT_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Weighted round-robin drain of NUM_PORTS FWFT FIFOs onto one registered
// valid/ready stream; each grant sends up to its port's quantum of words.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned QUANTUM_WIDTH = 4,
    parameter int unsigned PORT_WIDTH    = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_rdata,
    output logic [NUM_PORTS-1:0]            fifo_ren,
    input  logic [NUM_PORTS*QUANTUM_WIDTH-1:0] quantum,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PORT_WIDTH-1:0]           out_port,
    output logic                            busy
);

    sched_state_e              state;
    logic [PORT_WIDTH-1:0]     sel;
    logic [PORT_WIDTH-1:0]     last_port;
    logic [QUANTUM_WIDTH-1:0]  burst_cnt;

    logic [PORT_WIDTH-1:0]     base;
    logic [PORT_WIDTH-1:0]     grant;
    logic                      hit;
    logic [QUANTUM_WIDTH-1:0]  grant_quantum;
    logic                      slot_free;
    logic                      head_empty;
    logic                      pop;

    logic [DATA_WIDTH-1:0]     rdata_arr   [NUM_PORTS];
    logic [QUANTUM_WIDTH-1:0]  quantum_arr [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_arr[p]   = fifo_rdata[p*DATA_WIDTH +: DATA_WIDTH];
            quantum_arr[p] = quantum[p*QUANTUM_WIDTH +: QUANTUM_WIDTH];
        end
    end

    // Search starts one past the last served port so every port gets its turn.
    assign base = (last_port == PORT_WIDTH'(NUM_PORTS - 1)) ? '0
                                                             : last_port + PORT_WIDTH'(1);

    rr_pick #(
        .NUM_PORTS  (NUM_PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_rr_pick (
        .req   (~fifo_empty),
        .base  (base),
        .hit   (hit),
        .grant (grant)
    );

    assign grant_quantum = QUANTUM_WIDTH'(quantum_norm(MAX_QUANTUM_WIDTH'(quantum_arr[grant])));

    assign head_empty = fifo_empty[sel];
    assign slot_free  = !out_valid || out_ready;
    assign pop        = rst_n && (state == SERVE) && slot_free && !head_empty;

    always_comb begin
        fifo_ren = '0;
        if (pop) begin
            fifo_ren[sel] = 1'b1;
        end
    end

    assign busy = (state == SERVE) || out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            last_port <= PORT_WIDTH'(NUM_PORTS - 1);
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else begin
            if (out_ready && !pop) begin
                out_valid <= 1'b0;
            end
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= rdata_arr[sel];
                out_port  <= sel;
                burst_cnt <= burst_cnt - QUANTUM_WIDTH'(1);
            end

            unique case (state)
                IDLE: begin
                    if (hit) begin
                        sel       <= grant;
                        burst_cnt <= grant_quantum;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    // An empty head forfeits the rest of the quantum.
                    if ((pop && burst_cnt == QUANTUM_WIDTH'(1)) || head_empty) begin
                        state     <= IDLE;
                        last_port <= sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: bench-owned FIFO queues, a word-order model
// computed from the rotation/quantum rules, and per-cycle protocol checks.
module tb_fifo_rr_scheduler;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int QW = 4;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   fifo_empty;
    logic [NP*DW-1:0] fifo_rdata;
    logic [NP-1:0]   fifo_ren;
    logic [NP*QW-1:0] quantum;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [PW-1:0]   out_port;
    logic            busy;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(
        .NUM_PORTS     (NP),
        .DATA_WIDTH    (DW),
        .QUANTUM_WIDTH (QW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .quantum    (quantum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_port   (out_port),
        .busy       (busy)
    );

    logic [DW-1:0] fq [NP][$];
    int            exp_port[$];
    logic [DW-1:0] exp_data[$];
    int            lit[$];
    int            rd;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            first_acc;
    int            last_acc;
    int            base;
    bit            chk_stream;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [PW-1:0] prev_port;
    logic [NP-1:0] ren_s;
    int            rd_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_fifos();
        for (int p = 0; p < NP; p++) begin
            fifo_empty[p] = (fq[p].size() == 0);
            if (fq[p].size() != 0) fifo_rdata[p*DW +: DW] = fq[p][0];
            else                   fifo_rdata[p*DW +: DW] = '0;
        end
    endtask

    task automatic load(input int p, input int n, input int start);
        for (int i = 0; i < n; i++) fq[p].push_back(DW'(start + i));
        drive_fifos();
    endtask

    task automatic set_q_all(input int q);
        for (int p = 0; p < NP; p++) quantum[p*QW +: QW] = QW'(q);
    endtask

    // Expected accepted-word order from the current queue contents and rotation start.
    task automatic gen_expected();
        int pos[NP];
        int ptr;
        int w;
        int q;
        int take;
        bit found;
        exp_port.delete();
        exp_data.delete();
        rd = 0;
        first_acc = -1;
        last_acc = -1;
        for (int p = 0; p < NP; p++) pos[p] = 0;
        ptr = base;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < NP; k++) begin
                if (!found && pos[(ptr + k) % NP] < fq[(ptr + k) % NP].size()) begin
                    found = 1'b1;
                    w = (ptr + k) % NP;
                end
            end
            if (found) begin
                q = int'(quantum[w*QW +: QW]);
                if (q == 0) q = 1;
                take = fq[w].size() - pos[w];
                if (take > q) take = q;
                for (int i = 0; i < take; i++) begin
                    exp_port.push_back(w);
                    exp_data.push_back(fq[w][pos[w]]);
                    pos[w]++;
                end
                ptr = (w + 1) % NP;
            end
        end
        base = ptr;
    endtask

    task automatic pin(input string name);
        check({name, "_len"}, exp_port.size(), lit.size());
        for (int i = 0; i < lit.size() && i < exp_port.size(); i++) check(name, exp_port[i], lit[i]);
    endtask

    task automatic check_cycle();
        cyc++;
        if (!rst_n) begin
            check("ren_in_reset", fifo_ren, 0);
            prev_stall = 1'b0;
        end else begin
            check("ren_onehot", ($countones(fifo_ren) <= 1), 1);
            check("ren_of_empty", fifo_ren & fifo_empty, 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_port", out_port, prev_port);
            end
            if (out_valid && !out_ready) check("stall_ren", fifo_ren, 0);
            if (out_valid) check("busy_with_valid", busy, 1);
            if (chk_stream && out_valid && out_ready) begin
                if (rd < exp_port.size()) begin
                    check("word_port", out_port, exp_port[rd]);
                    check("word_data", out_data, exp_data[rd]);
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    rd++;
                end else begin
                    check("extra_word", rd, exp_port.size());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_port  = out_port;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        ren_s = fifo_ren;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (ren_s[p] && fq[p].size() > 0) void'(fq[p].pop_front());
        end
        drive_fifos();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        base = 0;
    endtask

    task automatic run(input int budget);
        int k;
        k = 0;
        while ((rd < exp_port.size() || busy) && k < budget) begin
            tick();
            k++;
        end
        check("drained", rd, exp_port.size());
        check("idle_at_end", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        quantum = '0;
        chk_stream = 1'b1;
        prev_stall = 1'b0;
        fifo_rdata = '0;
        fifo_empty = '1;
        rd = 0;
        drive_fifos();
        reset_dut();

        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_port", out_port, 0);
        check("rst_fifo_ren", fifo_ren, 0);

        // Single port, 5 words with quantum 4: 4 words, bubble, regrant, 1 word.
        set_q_all(4);
        load(0, 5, 'h10);
        gen_expected();
        lit = '{0, 0, 0, 0, 0};
        pin("s1_ports");
        check("s1_last_data", exp_data[4], 'h14);
        run(100);
        check("s1_window", last_acc - first_acc + 1, 6);

        // Quantum 1 on all ports: strict rotation, a bubble between every word.
        reset_dut();
        set_q_all(1);
        for (int p = 0; p < NP; p++) load(p, 2, 'h20 + p * 16);
        gen_expected();
        lit = '{0, 1, 2, 3, 0, 1, 2, 3};
        pin("s2_ports");
        run(100);
        check("s2_window", last_acc - first_acc + 1, 15);

        // Weighted: port 1 quantum 3, port 2 quantum 0 (served as 1).
        reset_dut();
        set_q_all(1);
        quantum[1*QW +: QW] = 4'd3;
        quantum[2*QW +: QW] = 4'd0;
        load(1, 6, 'h40);
        load(2, 6, 'h50);
        gen_expected();
        lit = '{1, 1, 1, 2, 1, 1, 1, 2, 2, 2, 2, 2};
        pin("s3_ports");
        run(100);

        // Backpressure mid-burst: burst count must hold across the stall.
        reset_dut();
        set_q_all(4);
        load(1, 6, 'h60);
        load(2, 2, 'h70);
        gen_expected();
        lit = '{1, 1, 1, 1, 2, 2, 1, 1};
        pin("s4_ports");
        tick();
        tick();
        tick();
        check("s4_valid_before_stall", out_valid, 1);
        out_ready = 1'b0;
        rd_before = rd;
        tick();
        tick();
        tick();
        check("s4_no_accept_in_stall", rd, rd_before);
        out_ready = 1'b1;
        run(100);

        // Early exit: port 3 empties after 2 of quantum 4, then port 0.
        load(3, 2, 'h80);
        load(0, 2, 'h90);
        gen_expected();
        lit = '{3, 3, 0, 0};
        pin("s5_ports");
        run(100);

        // Reset mid-burst: registered word dropped, next grant from port 0.
        chk_stream = 1'b0;
        load(2, 4, 'hA0);
        tick();
        tick();
        tick();
        tick();
        check("s6_valid_before_reset", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s6_valid_after_reset", out_valid, 0);
        check("s6_busy_after_reset", busy, 0);
        base = 0;
        load(0, 2, 'hB0);
        gen_expected();
        lit = '{0, 0, 2};
        pin("s6_ports");
        chk_stream = 1'b1;
        run(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
